// File: rtl/ppl_key_debounce.sv
// Key/switch conditioner: 2-flop synchroniser and counter debouncer per key, with
// one-cycle press/release pulses and a write-1-to-clear sticky press register.

module ppl_key_debounce_lane #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clock,
    input  logic clrn,
    input  logic raw,
    input  logic press_clr,
    output logic key,
    output logic press,
    output logic rel,
    output logic latch
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             key_q, key_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             latch_q, latch_d;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        key_d   = key_q;
        cnt_d   = '0;
        press_d = 1'b0;
        rel_d   = 1'b0;
        // Any cycle where the synchronised input agrees with the accepted level restarts the count.
        if (sync2_q != key_q) begin
            if (cnt_q == CNT_LAST) begin
                key_d   = sync2_q;
                press_d = sync2_q;
                rel_d   = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // A press landing on the same edge as a clear must not be lost.
        if (press_d)
            latch_d = 1'b1;
        else if (press_clr)
            latch_d = 1'b0;
        else
            latch_d = latch_q;
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            key_q   <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            latch_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            latch_q <= latch_d;
        end
    end

    assign key   = key_q;
    assign press = press_q;
    assign rel   = rel_q;
    assign latch = latch_q;

endmodule

module ppl_key_debounce #(
    parameter int N_KEYS          = 10,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic              clock,
    input  logic              clrn,
    input  logic [N_KEYS-1:0] keys_raw,
    input  logic [N_KEYS-1:0] press_clr,
    output logic [N_KEYS-1:0] keys,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] press_latch
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_lane
        ppl_key_debounce_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_lane (
            .clock    (clock),
            .clrn     (clrn),
            .raw      (keys_raw[i]),
            .press_clr(press_clr[i]),
            .key      (keys[i]),
            .press    (key_press[i]),
            .rel      (key_release[i]),
            .latch    (press_latch[i])
        );
    end

endmodule

// File: tb/tb_ppl_key_debounce.sv
// Bench for ppl_key_debounce: directed scenarios plus random key/clear/reset traffic,
// checked every cycle against a timestamp-based reference model.

module tb_ppl_key_debounce;

    localparam int N  = 10;
    localparam int D  = 4;
    localparam int CW = 3;

    logic         clock = 1'b0;
    logic         clrn;
    logic [N-1:0] keys_raw, press_clr;
    logic [N-1:0] keys, key_press, key_release, press_latch;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: a key accepts the synchronised level once that level has disagreed
    // with the accepted one on D consecutive edges, measured from the last agreement.
    logic [N-1:0] m_s1, m_s2, m_keys, m_press, m_rel, m_latch;
    int           m_edge;
    int           m_agree_edge [N];

    always #5 clock = ~clock;

    ppl_key_debounce #(
        .N_KEYS         (N),
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (CW)
    ) dut (
        .clock      (clock),
        .clrn       (clrn),
        .keys_raw   (keys_raw),
        .press_clr  (press_clr),
        .keys       (keys),
        .key_press  (key_press),
        .key_release(key_release),
        .press_latch(press_latch)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_clear();
        m_s1 = '0; m_s2 = '0; m_keys = '0;
        m_press = '0; m_rel = '0; m_latch = '0;
        m_edge = 0;
        for (int i = 0; i < N; i++) m_agree_edge[i] = 0;
    endtask

    task automatic check_outputs();
        chk("keys",        32'(keys),        32'(m_keys));
        chk("key_press",   32'(key_press),   32'(m_press));
        chk("key_release", 32'(key_release), 32'(m_rel));
        chk("press_latch", 32'(press_latch), 32'(m_latch));
    endtask

    // Advance model and DUT by one rising edge using the inputs currently applied.
    task automatic step();
        m_edge++;
        for (int i = 0; i < N; i++) begin
            m_press[i] = 1'b0;
            m_rel[i]   = 1'b0;
            if (m_s2[i] == m_keys[i]) begin
                m_agree_edge[i] = m_edge;
            end else if (m_edge - m_agree_edge[i] >= D) begin
                m_keys[i]       = m_s2[i];
                m_press[i]      = m_s2[i];
                m_rel[i]        = ~m_s2[i];
                m_agree_edge[i] = m_edge;
            end
            if (m_press[i])        m_latch[i] = 1'b1;
            else if (press_clr[i]) m_latch[i] = 1'b0;
        end
        m_s2 = m_s1;
        m_s1 = keys_raw;
        @(posedge clock);
        #1;
        check_outputs();
    endtask

    // Called just after a rising edge; asserts reset mid-cycle and releases it after 'hold' edges.
    task automatic pulse_reset(input int hold);
        #2 clrn = 1'b0;
        #1;
        model_clear();
        chk("rst_keys",    32'(keys),        32'd0);
        chk("rst_press",   32'(key_press),   32'd0);
        chk("rst_release", 32'(key_release), 32'd0);
        chk("rst_latch",   32'(press_latch), 32'd0);
        repeat (hold) @(posedge clock);
        #1 clrn = 1'b1;
    endtask

    initial begin
        logic seen;
        clrn      = 1'b0;
        keys_raw  = '1;
        press_clr = '0;
        model_clear();

        // Reset held before the first clock edge
        #2;
        check_outputs();
        repeat (2) @(posedge clock);
        #1;
        keys_raw = '0;
        clrn     = 1'b1;
        repeat (3) step();

        // Press key 9
        keys_raw[9] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 5) chk("t2_key9_early", 32'(keys[9]), 32'd0);
            if (k == 6) begin
                chk("t2_key9_rise",  32'(keys[9]),      32'd1);
                chk("t2_press9",     32'(key_press[9]), 32'd1);
            end
            if (k == 7) begin
                chk("t2_press9_end", 32'(key_press[9]),   32'd0);
                chk("t2_latch9",     32'(press_latch[9]), 32'd1);
            end
        end

        // Bouncing key 4: three-cycle highs never get through
        seen = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int ph = 0; ph < 4; ph++) begin
                keys_raw[4] = (ph < 3);
                step();
                seen |= keys[4] | key_press[4] | key_release[4];
            end
        end
        chk("t3_bounce_quiet", 32'(seen), 32'd0);
        keys_raw[4] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 5) chk("t3_key4_early", 32'(keys[4]), 32'd0);
            if (k == 6) chk("t3_key4_rise",  32'(keys[4]), 32'd1);
        end

        // Release key 9
        keys_raw[9] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 6) begin
                chk("t4_key9_fall", 32'(keys[9]),        32'd0);
                chk("t4_release9",  32'(key_release[9]), 32'd1);
                chk("t4_latch9",    32'(press_latch[9]), 32'd1);
            end
            if (k == 7) chk("t4_release9_end", 32'(key_release[9]), 32'd0);
        end

        // Clear latch, then clear on the same edge as a new press
        press_clr[9] = 1'b1;
        step();
        press_clr[9] = 1'b0;
        chk("t5_latch9_clr", 32'(press_latch[9]), 32'd0);
        keys_raw[9] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            if (k == 6) press_clr[9] = 1'b1;
            step();
        end
        chk("t5_press9_vs_clr", 32'(key_press[9]),   32'd1);
        chk("t5_latch9_wins",   32'(press_latch[9]), 32'd1);
        press_clr[9] = 1'b0;
        step();
        chk("t5_latch9_hold",   32'(press_latch[9]), 32'd1);

        // Reset in the middle of a key-2 count; raw stays high afterwards
        keys_raw[2] = 1'b1;
        repeat (2) step();
        pulse_reset(1);
        seen = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k < 6) seen |= keys[2] | key_press[2];
            if (k == 6) begin
                chk("t6_key2_rise",  32'(keys[2]),      32'd1);
                chk("t6_press2",     32'(key_press[2]), 32'd1);
                chk("t6_simul_press", 32'(key_press),   32'h214);
            end
        end
        chk("t6_no_early_press", 32'(seen), 32'd0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) pulse_reset($urandom_range(1, 3));
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 5) == 0) keys_raw[i] = ~keys_raw[i];
            press_clr = N'($urandom & $urandom & $urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
